// File: rtl/fp_mul_param_if.sv
// Start/done handshake and operand/result bundle for the iterative FP multiplier.
interface fp_mul_param_if #(
   parameter int unsigned W = 32
);
   logic         start_i;
   logic [W-1:0] a_i;
   logic [W-1:0] b_i;
   logic         rnd_mode_i;
   logic [W-1:0] product_o;
   logic         busy_o;
   logic         done_o;
   logic         nan_o;
   logic         infinit_o;
   logic         overflow_o;
   logic         underflow_o;

   modport master (
      output start_i, a_i, b_i, rnd_mode_i,
      input  product_o, busy_o, done_o, nan_o, infinit_o, overflow_o, underflow_o
   );

   modport slave (
      input  start_i, a_i, b_i, rnd_mode_i,
      output product_o, busy_o, done_o, nan_o, infinit_o, overflow_o, underflow_o
   );
endinterface

// File: rtl/fp_mul_param.sv
// Parametrised IEEE-754 multiplier: shift-add significand product (one bit per
// cycle), subnormal inputs treated as zero, flush-to-zero on underflow, RNE/RTZ.
module fp_mul_param #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input logic           clk,
   input logic           rst,
   fp_mul_param_if.slave bus
);
   localparam int unsigned SIG_W  = MAN_W + 1;
   localparam int unsigned W      = 1 + EXP_W + MAN_W;
   localparam int unsigned PROD_W = 2 * SIG_W;
   localparam int unsigned E2_W   = EXP_W + 2;
   localparam int unsigned CNT_W  = $clog2(SIG_W);
   localparam int unsigned BIAS   = (2 ** (EXP_W - 1)) - 1;
   localparam int unsigned EMAX   = (2 ** EXP_W) - 1;
   localparam logic signed [E2_W-1:0] E_MAX = E2_W'(EMAX);

   typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND, DONE} state_t;

   state_t state, next_state;

   logic [W-1:0]            a_r, b_r;
   logic                    rnd_r;
   logic                    sign_r;
   logic signed [E2_W-1:0]  exp_r;
   logic [SIG_W-1:0]        mcand_r;
   logic [PROD_W-1:0]       prod_r;
   logic [CNT_W-1:0]        cnt_r;
   logic [SIG_W-1:0]        mant_r;
   logic                    g_r, s_r;

   // operand classification
   logic [EXP_W-1:0] ea_c, eb_c;
   logic [MAN_W-1:0] fa_c, fb_c;
   logic a_nan_c, b_nan_c, a_inf_c, b_inf_c, a_zero_c, b_zero_c;
   logic is_nan_c, is_inf_c, special_c, sign_c;
   logic signed [E2_W-1:0] exp_sum_c;
   logic [W-1:0] spec_res_c;

   assign ea_c     = a_r[W-2:MAN_W];
   assign eb_c     = b_r[W-2:MAN_W];
   assign fa_c     = a_r[MAN_W-1:0];
   assign fb_c     = b_r[MAN_W-1:0];
   assign a_nan_c  = (&ea_c) & (|fa_c);
   assign b_nan_c  = (&eb_c) & (|fb_c);
   assign a_inf_c  = (&ea_c) & ~(|fa_c);
   assign b_inf_c  = (&eb_c) & ~(|fb_c);
   assign a_zero_c = ~(|ea_c);
   assign b_zero_c = ~(|eb_c);
   assign sign_c   = a_r[W-1] ^ b_r[W-1];
   assign is_nan_c = a_nan_c | b_nan_c | (a_inf_c & b_zero_c) | (b_inf_c & a_zero_c);
   assign is_inf_c = a_inf_c | b_inf_c;
   assign special_c = is_nan_c | is_inf_c | a_zero_c | b_zero_c;
   assign exp_sum_c = E2_W'(ea_c) + E2_W'(eb_c) - E2_W'(BIAS);

   // special-case result in priority order: NaN, infinity, zero
   always_comb begin
      spec_res_c = {sign_c, {(W-1){1'b0}}};
      if (is_nan_c)
         spec_res_c = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      else if (is_inf_c)
         spec_res_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
   end

   // one shift-add step; the low half of prod_r holds the unconsumed multiplier bits
   logic [SIG_W:0] sum_c;
   assign sum_c = {1'b0, prod_r[PROD_W-1:SIG_W]} + (prod_r[0] ? {1'b0, mcand_r} : '0);

   // normalisation and guard/sticky extraction
   logic [SIG_W-1:0]       nmant_c;
   logic                   ng_c, ns_c;
   logic signed [E2_W-1:0] nexp_c;
   always_comb begin
      nmant_c = prod_r[PROD_W-2 -: SIG_W];
      ng_c    = prod_r[SIG_W-2];
      ns_c    = |prod_r[SIG_W-3:0];
      nexp_c  = exp_r;
      if (prod_r[PROD_W-1]) begin
         nmant_c = prod_r[PROD_W-1 -: SIG_W];
         ng_c    = prod_r[SIG_W-1];
         ns_c    = |prod_r[SIG_W-2:0];
         nexp_c  = exp_r + E2_W'(1);
      end
   end

   // rounding, underflow flush and overflow saturation
   logic                   inc_c, unf_c, ovf_c;
   logic [SIG_W:0]         rsum_c;
   logic [MAN_W-1:0]       rfrac_c;
   logic signed [E2_W-1:0] rexp_c;
   logic [W-1:0]           round_res_c;
   always_comb begin
      inc_c   = ~rnd_r & g_r & (s_r | mant_r[0]);
      rsum_c  = {1'b0, mant_r} + (SIG_W+1)'(inc_c);
      rfrac_c = rsum_c[MAN_W-1:0];
      rexp_c  = exp_r;
      if (rsum_c[SIG_W]) begin
         rfrac_c = rsum_c[SIG_W-1:1];
         rexp_c  = exp_r + E2_W'(1);
      end
      unf_c = exp_r[E2_W-1] | (exp_r == '0);
      ovf_c = ~unf_c & (rexp_c >= E_MAX);
      round_res_c = {sign_r, rexp_c[EXP_W-1:0], rfrac_c};
      if (unf_c)
         round_res_c = {sign_r, {(W-1){1'b0}}};
      else if (ovf_c && rnd_r)
         round_res_c = {sign_r, EXP_W'(EMAX - 1), {MAN_W{1'b1}}};
      else if (ovf_c)
         round_res_c = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start_i) next_state = UNPACK;
         UNPACK:  next_state = special_c ? DONE : MULT;
         MULT:    if (cnt_r == CNT_W'(SIG_W - 1)) next_state = NORM;
         NORM:    next_state = ROUND;
         ROUND:   next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // datapath registers and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r             <= '0;
         b_r             <= '0;
         rnd_r           <= 1'b0;
         sign_r          <= 1'b0;
         exp_r           <= '0;
         mcand_r         <= '0;
         prod_r          <= '0;
         cnt_r           <= '0;
         mant_r          <= '0;
         g_r             <= 1'b0;
         s_r             <= 1'b0;
         bus.product_o   <= '0;
         bus.busy_o      <= 1'b0;
         bus.done_o      <= 1'b0;
         bus.nan_o       <= 1'b0;
         bus.infinit_o   <= 1'b0;
         bus.overflow_o  <= 1'b0;
         bus.underflow_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start_i) begin
                  a_r             <= bus.a_i;
                  b_r             <= bus.b_i;
                  rnd_r           <= bus.rnd_mode_i;
                  bus.product_o   <= '0;
                  bus.nan_o       <= 1'b0;
                  bus.infinit_o   <= 1'b0;
                  bus.overflow_o  <= 1'b0;
                  bus.underflow_o <= 1'b0;
               end
            end
            UNPACK: begin
               sign_r  <= sign_c;
               exp_r   <= exp_sum_c;
               mcand_r <= {1'b1, fa_c};
               prod_r  <= {SIG_W'(0), 1'b1, fb_c};
               cnt_r   <= '0;
               if (special_c) begin
                  bus.product_o <= spec_res_c;
                  bus.nan_o     <= is_nan_c;
                  bus.infinit_o <= ~is_nan_c & is_inf_c;
               end
            end
            MULT: begin
               prod_r <= {sum_c, prod_r[SIG_W-1:1]};
               cnt_r  <= cnt_r + CNT_W'(1);
            end
            NORM: begin
               mant_r <= nmant_c;
               g_r    <= ng_c;
               s_r    <= ns_c;
               exp_r  <= nexp_c;
            end
            ROUND: begin
               bus.product_o   <= round_res_c;
               bus.overflow_o  <= ovf_c;
               bus.infinit_o   <= ovf_c & ~rnd_r;
               bus.underflow_o <= unf_c;
            end
            default: ;
         endcase
         bus.done_o <= (next_state == DONE);
         bus.busy_o <= (next_state != IDLE);
      end
   end
endmodule

// File: tb/tb_fp_mul_param.sv
// Self-checking bench for fp_mul_param: directed cases plus randomized operands
// compared against an arithmetic reference model (binary32 and binary16).
module tb_fp_mul_param;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   ncmp = 0;
   int   nfail = 0;

   always #5 clk = ~clk;

   fp_mul_param_if #(.W(32)) bus32 ();
   fp_mul_param_if #(.W(16)) bus16 ();

   fp_mul_param #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
   fp_mul_param #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

   typedef struct packed {
      logic [31:0] p;
      logic [3:0]  fl;
      logic        special;
   } ref_t;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // value-level model: exact integer product, round by remainder vs half-ulp
   function automatic ref_t ref_mul(input int ew, input int mw, input logic [31:0] a,
                                    input logic [31:0] b, input bit rtz);
      ref_t r;
      longint unsigned av, bv, emax, bias, fmask, fa, fb, ea, eb, sign, pr, mant, rem, half;
      longint e;
      int sh;
      bit an, bn, ai, bi, az, bz;
      av = 64'(a); bv = 64'(b);
      emax  = (64'd1 << ew) - 1;
      bias  = (64'd1 << (ew - 1)) - 1;
      fmask = (64'd1 << mw) - 1;
      fa = av & fmask; fb = bv & fmask;
      ea = (av >> mw) & emax; eb = (bv >> mw) & emax;
      sign = ((av ^ bv) >> (ew + mw)) & 1;
      an = (ea == emax) && (fa != 0); bn = (eb == emax) && (fb != 0);
      ai = (ea == emax) && (fa == 0); bi = (eb == emax) && (fb == 0);
      az = (ea == 0); bz = (eb == 0);
      r = '0;
      r.special = 1'b1;
      if (an || bn || (ai && bz) || (bi && az)) begin
         r.p = 32'((emax << mw) | (64'd1 << (mw - 1)));
         r.fl = 4'b1000;
         return r;
      end
      if (ai || bi) begin
         r.p = 32'((sign << (ew + mw)) | (emax << mw));
         r.fl = 4'b0100;
         return r;
      end
      if (az || bz) begin
         r.p = 32'(sign << (ew + mw));
         return r;
      end
      r.special = 1'b0;
      pr = (fa | (64'd1 << mw)) * (fb | (64'd1 << mw));
      e = $signed(ea + eb) - $signed(bias);
      if (pr >= (64'd1 << (2 * mw + 1))) begin sh = mw + 1; e++; end
      else sh = mw;
      if (e <= 0) begin
         r.p = 32'(sign << (ew + mw));
         r.fl = 4'b0001;
         return r;
      end
      mant = pr >> sh;
      rem  = pr & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (!rtz && (rem > half || (rem == half && mant[0]))) mant++;
      if (mant == (64'd1 << (mw + 1))) begin mant = mant >> 1; e++; end
      if (e >= $signed(emax)) begin
         if (rtz) begin
            r.p = 32'((sign << (ew + mw)) | ((emax - 1) << mw) | fmask);
            r.fl = 4'b0010;
         end else begin
            r.p = 32'((sign << (ew + mw)) | (emax << mw));
            r.fl = 4'b0110;
         end
         return r;
      end
      r.p = 32'((sign << (ew + mw)) | ($unsigned(e) << mw) | (mant & fmask));
      return r;
   endfunction

   function automatic logic [31:0] gen(input int ew, input int mw);
      longint unsigned emax, bias, e, f, s;
      int k;
      emax = (64'd1 << ew) - 1;
      bias = (64'd1 << (ew - 1)) - 1;
      k = int'($urandom_range(0, 9));
      f = 64'($urandom) & ((64'd1 << mw) - 1);
      s = 64'($urandom_range(0, 1));
      if (k <= 5)      e = bias - bias / 2 + 64'($urandom_range(0, 32'(bias)));
      else if (k == 6) e = 64'($urandom_range(0, 32'(emax)));
      else if (k == 7) e = emax - 1 - 64'($urandom_range(0, 32'(bias / 2)));
      else if (k == 8) e = 1 + 64'($urandom_range(0, 32'(bias / 2)));
      else begin
         e = ($urandom_range(0, 1) == 1) ? emax : 0;
         if ($urandom_range(0, 1) == 1) f = 0;
      end
      return 32'((s << (ew + mw)) | (e << mw) | f);
   endfunction

   // one transaction; lat = cycle (counted from the start-sampling edge) in which done is seen
   task automatic run_op(input bit h, input logic [31:0] a, input logic [31:0] b, input bit rtz,
                         output logic [31:0] p, output logic [3:0] fl, output int lat);
      @(negedge clk);
      if (h) begin
         bus16.start_i = 1'b1; bus16.a_i = a[15:0]; bus16.b_i = b[15:0]; bus16.rnd_mode_i = rtz;
      end else begin
         bus32.start_i = 1'b1; bus32.a_i = a; bus32.b_i = b; bus32.rnd_mode_i = rtz;
      end
      @(negedge clk);
      bus16.start_i = 1'b0;
      bus32.start_i = 1'b0;
      lat = 1;
      while (!(h ? bus16.done_o : bus32.done_o) && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (h) begin
         p  = {16'h0, bus16.product_o};
         fl = {bus16.nan_o, bus16.infinit_o, bus16.overflow_o, bus16.underflow_o};
      end else begin
         p  = bus32.product_o;
         fl = {bus32.nan_o, bus32.infinit_o, bus32.overflow_o, bus32.underflow_o};
      end
   endtask

   task automatic directed(input string tag, input bit h, input logic [31:0] a, input logic [31:0] b,
                           input bit rtz, input logic [31:0] ep, input logic [3:0] efl, input int elat);
      logic [31:0] p;
      logic [3:0]  fl;
      int          lat;
      run_op(h, a, b, rtz, p, fl, lat);
      check({tag, "_prod"}, 64'(p), 64'(ep));
      check({tag, "_flags"}, 64'(fl), 64'(efl));
      check({tag, "_lat"}, 64'(lat), 64'(elat));
   endtask

   task automatic random_op(input bit h, input int i);
      logic [31:0] a, b, p;
      logic [3:0]  fl;
      int          lat, ew, mw;
      bit          rtz;
      ref_t        r;
      ew = h ? 5 : 8;
      mw = h ? 10 : 23;
      a = gen(ew, mw);
      b = gen(ew, mw);
      rtz = (i % 2) == 1;
      r = ref_mul(ew, mw, a, b, rtz);
      run_op(h, a, b, rtz, p, fl, lat);
      check($sformatf("rnd%0d_%0d_prod a=%h b=%h m=%0d", ew, i, a, b, rtz), 64'(p), 64'(r.p));
      check($sformatf("rnd%0d_%0d_flags", ew, i), 64'(fl), 64'(r.fl));
      check($sformatf("rnd%0d_%0d_lat", ew, i), 64'(lat), r.special ? 64'd2 : 64'(mw + 5));
   endtask

   initial begin
      logic [31:0] p;
      logic [3:0]  fl;
      int          lat;
      bit          saw;

      bus32.start_i = 1'b0; bus32.a_i = '0; bus32.b_i = '0; bus32.rnd_mode_i = 1'b0;
      bus16.start_i = 1'b0; bus16.a_i = '0; bus16.b_i = '0; bus16.rnd_mode_i = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      check("reset_outs", 64'({bus32.product_o, bus32.busy_o, bus32.done_o, bus32.nan_o,
                               bus32.infinit_o, bus32.overflow_o, bus32.underflow_o}), 64'd0);
      rst = 1'b0;

      directed("t1", 1'b0, 32'h40200000, 32'h40800000, 1'b0, 32'h41200000, 4'b0000, 28);
      @(negedge clk);
      check("t1_done_pulse", 64'({bus32.done_o, bus32.busy_o}), 64'd0);
      check("t1_held", 64'(bus32.product_o), 64'h41200000);

      directed("t2_rne", 1'b0, 32'h3F800001, 32'h3FC00000, 1'b0, 32'h3FC00002, 4'b0000, 28);
      directed("t2_rtz", 1'b0, 32'h3F800001, 32'h3FC00000, 1'b1, 32'h3FC00001, 4'b0000, 28);
      directed("t3_nan", 1'b0, 32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000, 2);
      directed("t3_inf", 1'b0, 32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 4'b0100, 2);
      directed("t4_rne", 1'b0, 32'h7F000000, 32'h40000000, 1'b0, 32'h7F800000, 4'b0110, 28);
      directed("t4_rtz", 1'b0, 32'h7F000000, 32'h40000000, 1'b1, 32'h7F7FFFFF, 4'b0010, 28);
      directed("t5_unf", 1'b0, 32'h00800000, 32'h3F000000, 1'b0, 32'h00000000, 4'b0001, 28);

      // accepted start clears result/flags; reset at cycle 10 aborts with no done
      @(negedge clk);
      bus32.start_i = 1'b1; bus32.a_i = 32'h40200000; bus32.b_i = 32'h40800000; bus32.rnd_mode_i = 1'b0;
      @(negedge clk);
      bus32.start_i = 1'b0;
      check("start_clears", 64'({bus32.product_o, bus32.nan_o, bus32.infinit_o,
                                 bus32.overflow_o, bus32.underflow_o}), 64'd0);
      check("start_busy", 64'(bus32.busy_o), 64'd1);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midop_reset", 64'({bus32.product_o, bus32.busy_o, bus32.done_o, bus32.nan_o,
                                bus32.infinit_o, bus32.overflow_o, bus32.underflow_o}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      saw = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus32.done_o || bus32.busy_o) saw = 1'b1;
      end
      check("abort_no_done", 64'(saw), 64'd0);

      // start while busy is ignored
      @(negedge clk);
      bus32.start_i = 1'b1; bus32.a_i = 32'h40200000; bus32.b_i = 32'h40800000; bus32.rnd_mode_i = 1'b0;
      @(negedge clk);
      bus32.start_i = 1'b0;
      lat = 1;
      @(negedge clk);
      lat++;
      bus32.start_i = 1'b1; bus32.a_i = 32'h3F800001; bus32.b_i = 32'h3FC00000; bus32.rnd_mode_i = 1'b1;
      repeat (3) begin @(negedge clk); lat++; end
      bus32.start_i = 1'b0;
      while (!bus32.done_o && lat < 200) begin @(negedge clk); lat++; end
      check("busy_ign_prod", 64'(bus32.product_o), 64'h41200000);
      check("busy_ign_lat", 64'(lat), 64'd28);
      saw = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus32.done_o) saw = 1'b1;
      end
      check("busy_ign_no_2nd", 64'(saw), 64'd0);

      directed("t6_h", 1'b1, 32'h4000, 32'h4200, 1'b0, 32'h4600, 4'b0000, 15);

      for (int i = 0; i < 60; i++) random_op(1'b0, i);
      for (int i = 0; i < 30; i++) random_op(1'b1, i);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
